rca_pipe: RTL and testbench
===========================

Name: rca_pipe

Overview:
- Parametrised, pipelined, segmented ripple-carry adder/subtractor for the datapath of the complex multiplier.
- Operands are split into SEG-bit segments. Each pipeline stage ripples one segment using the registered carry from the previous stage.
- Operands and partial sums are skewed and deskewed so a full-width result emerges with throughput of 1 op/cycle.
- Valid/ready handshake on both sides; global stall on backpressure.

Parameters:
- WIDTH, 16, operand/sum width in bits.
- SEG, 4, segment width (bits rippled per stage). WIDTH % SEG != 0 is an elaboration error.
- NSEG, WIDTH/SEG, derived (localparam): number of stages, equal to the latency in cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept an input this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (borrow-in when sub=1)
- sub  in  1  1 = subtract (A - B - cin), 0 = add (A + B + cin)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum/difference
- cout  out  1  carry-out of MSB (for sub: 1 = no borrow)
- ovf  out  1  signed overflow

Behaviour:
- Reset (async, rst_n=0): all stage valid bits, skew/deskew registers, carries, s, cout and ovf clear to 0 immediately. out_valid=0. in_ready=1 after release. In-flight ops are discarded.
- Advance condition: adv = !out_valid || out_ready.
  - in_ready = adv, combinational.
  - Accept occurs when in_valid && in_ready.
  - When adv=0, every pipeline register holds, including valid bits.
- Operand preprocessing at stage 0:
  - b_eff = sub ? ~b : b.
  - c0 = cin ^ sub.
  - sub=1, cin=0 gives A-B; sub=1, cin=1 gives A-B-1.
- Stage k (0..NSEG-1):
  - Computes seg_k = a[k] + b_eff[k] + c_k, where c_k is the carry registered by stage k-1 (c0 at stage 0).
  - Registers the SEG-bit sum and carry-out.
  - Upper segments (j>k) travel through skew registers.
  - Lower completed sums travel through deskew registers.
- Last stage:
  - Registers s = concatenation of all segment sums and cout = carry out of segment NSEG-1.
  - ovf = carry into MSB XOR carry out of MSB, computed inside the last stage.
- Latency: exactly NSEG advancing cycles from accept to out_valid=1 for that op. With out_ready held high this equals NSEG clock cycles.
- Throughput: 1 op/cycle when in_valid and out_ready are continuously high. Order is preserved. Bubbles (in_valid=0) propagate as invalid slots.
- Output stability: while out_valid=1 and out_ready=0, s, cout and ovf hold.
- Simultaneous accept and output handoff in the same cycle is legal and required for full throughput.
- Arithmetic is modulo 2^WIDTH; no saturation.
- NSEG=1 degenerates to a single registered adder (latency 1).

Test Plan:
- Reset: assert rst_n=0 mid-stream with 3 ops in flight. Required: out_valid=0 and s=0 asynchronously, before the next clk edge. After release, the first new op appears exactly 4 cycles after accept; no stale result appears.
- Carry across all segments (WIDTH=16, SEG=4): a=0xFFFF, b=0x0001, cin=0, sub=0. Required: s=0x0000, cout=1, ovf=0, with out_valid 4 cycles after accept. Also a=0x7FFF, b=0x0001, giving s=0x8000, cout=0, ovf=1.
- Subtract:
  - a=0x0003, b=0x0005, sub=1, cin=0 gives s=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 gives s=0x7FFF, cout=1, ovf=1.
  - a=0x0010, b=0x0001, sub=1, cin=1 gives s=0x000E, cout=1.
- Streaming: 200 back-to-back random ops (random sub/cin) with out_ready=1. Required: one result per cycle, in order, every result matching the golden model.
- Backpressure: with the pipeline full, drop out_ready for 3 cycles. Required: in_ready=0 during the stall; s, cout and ovf stable; no loss or duplication on resume.
- Bubbles and parameter sweep:
  - Random in_valid and out_ready: the output sequence must equal the input sequence.
  - Repeat the full bench at WIDTH=8/SEG=8 (latency 1) and WIDTH=32/SEG=8 (latency 4).

Source files
------------

// File: rtl/rca_pipe.sv
// rca_pipe: pipelined, segmented ripple-carry adder/subtractor.
// Stage k ripples segment k using the carry registered by stage k-1. Operand
// segments not yet consumed ride along in skew registers, and completed
// segment sums ride along in deskew registers, so one full-width result
// leaves the last stage per cycle.
module rca_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int unsigned NSEG = WIDTH / SEG;

    if (WIDTH % SEG != 0) begin : g_bad_seg
        $error("rca_pipe: WIDTH must be a multiple of SEG");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Per-stage inputs: operands still to be summed and sums completed so far
    logic [WIDTH-1:0] a_in   [NSEG];
    logic [WIDTH-1:0] b_in   [NSEG];
    logic [WIDTH-1:0] sum_in [NSEG];
    logic [NSEG-1:0]  c_in;
    logic [NSEG-1:0]  v_in;

    // Per-stage next-state
    logic [SEG:0]     seg_sum [NSEG];
    logic [WIDTH-1:0] sum_d   [NSEG];
    logic [NSEG-1:0]  c_d;
    logic             ovf_d;

    // Pipeline registers
    logic [WIDTH-1:0] a_q   [NSEG];
    logic [WIDTH-1:0] b_q   [NSEG];
    logic [WIDTH-1:0] sum_q [NSEG];
    logic [NSEG-1:0]  c_q;
    logic [NSEG-1:0]  v_q;
    logic             ovf_q;

    // Global advance: the whole pipe moves only when the output slot frees up
    assign adv         = !out_valid_o || out_ready_i;
    assign in_ready_o  = adv;

    // Subtraction is A + ~B + 1; cin acts as a borrow, hence the inversion
    assign b_eff = sub_i ? ~b_i : b_i;
    assign c0    = cin_i ^ sub_i;

    // Route each stage's inputs from the ports (stage 0) or the previous stage
    always_comb begin
        a_in[0]   = a_i;
        b_in[0]   = b_eff;
        sum_in[0] = '0;
        c_in[0]   = c0;
        v_in[0]   = in_valid_i;
        for (int k = 1; k < int'(NSEG); k++) begin
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            sum_in[k] = sum_q[k-1];
            c_in[k]   = c_q[k-1];
            v_in[k]   = v_q[k-1];
        end
    end

    // Each stage adds its own segment and splices it into the running sum
    always_comb begin
        for (int k = 0; k < int'(NSEG); k++) begin
            seg_sum[k] = {1'b0, a_in[k][k*SEG +: SEG]}
                       + {1'b0, b_in[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, c_in[k]};
            sum_d[k] = sum_in[k];
            sum_d[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
            c_d[k] = seg_sum[k][SEG];
        end
    end

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit position
    always_comb begin
        ovf_d = a_in[NSEG-1][WIDTH-1] ^ b_in[NSEG-1][WIDTH-1] ^ sum_d[NSEG-1][WIDTH-1]
              ^ c_d[NSEG-1];
    end

    // Pipeline state: everything clears on reset and holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < int'(NSEG); k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (adv) begin
            v_q   <= v_in;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < int'(NSEG); k++) begin
                a_q[k]   <= a_in[k];
                b_q[k]   <= b_in[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign out_valid_o = v_q[NSEG-1];
    assign s_o         = sum_q[NSEG-1];
    assign cout_o      = c_q[NSEG-1];
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_rca_pipe.sv
// tb_rca_pipe: self-checking bench for rca_pipe. The main instance is 16/4;
// two extra instances (8/8 and 32/8) share the stimulus with out_ready tied
// high. All results are checked against a signed/unsigned arithmetic model.
module tb_rca_pipe;
    localparam int W = 16;
    localparam int S = 4;
    localparam int L = W / S;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, out_ready, cin, sub;
    logic [31:0] a32, b32;

    logic        in_ready, out_valid, cout, ovf;
    logic [15:0] s;
    logic        in_ready8, out_valid8, cout8, ovf8;
    logic [7:0]  s8;
    logic        in_ready32, out_valid32, cout32, ovf32;
    logic [31:0] s32;

    logic [33:0] qm[$];
    logic [33:0] q8[$];
    logic [33:0] q32[$];
    int          n_total = 0;
    int          n_bad = 0;
    int          n_out = 0;
    int          n_acc = 0;

    logic [15:0] d_a  [5] = '{16'hFFFF, 16'h7FFF, 16'h0003, 16'h8000, 16'h0010};
    logic [15:0] d_b  [5] = '{16'h0001, 16'h0001, 16'h0005, 16'h0001, 16'h0001};
    logic        d_c  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        d_sb [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] d_s  [5] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h000E};
    logic        d_co [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        d_ov [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    rca_pipe #(.WIDTH(W), .SEG(S)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a32[15:0]), .b_i(b32[15:0]), .cin_i(cin), .sub_i(sub),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .s_o(s), .cout_o(cout), .ovf_o(ovf)
    );

    rca_pipe #(.WIDTH(8), .SEG(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready8),
        .a_i(a32[7:0]), .b_i(b32[7:0]), .cin_i(cin), .sub_i(sub),
        .out_valid_o(out_valid8), .out_ready_i(1'b1),
        .s_o(s8), .cout_o(cout8), .ovf_o(ovf8)
    );

    rca_pipe #(.WIDTH(32), .SEG(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready32),
        .a_i(a32), .b_i(b32), .cin_i(cin), .sub_i(sub),
        .out_valid_o(out_valid32), .out_ready_i(1'b1),
        .s_o(s32), .cout_o(cout32), .ovf_o(ovf32)
    );

    // Reference: exact integer arithmetic, then range tests for carry and overflow
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic ci, input logic sb);
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(a) & m;
        longint ub   = longint'(b) & m;
        longint sa   = (ua >= half) ? ua - (m + 1) : ua;
        longint sbv  = (ub >= half) ? ub - (m + 1) : ub;
        longint c    = longint'(ci);
        longint r, sr;
        logic   co, ov;
        if (sb) begin
            r  = ua - ub - c;
            co = (r >= 0);
            sr = sa - sbv - c;
        end else begin
            r  = ua + ub + c;
            co = (r > m);
            sr = sa + sbv + c;
        end
        ov = (sr >= half) || (sr < -half);
        return {ov, co, 32'(r & m)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // In-flight ops are discarded by reset, so their expectations go too
    always @(negedge rst_n) begin
        qm.delete();
        q8.delete();
        q32.delete();
    end

    // Scoreboards sample at negedge: handoffs and accepts for the coming posedge
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (qm.size() == 0) check("m_spurious", 64'(out_valid), 64'(0));
                else check("m_data", 64'({ovf, cout, 16'h0000, s}), 64'(qm.pop_front()));
            end
            if (in_valid && in_ready) begin
                n_acc++;
                qm.push_back(ref_op(W, a32, b32, cin, sub));
            end
            if (out_valid8) begin
                if (q8.size() == 0) check("x8_spurious", 64'(out_valid8), 64'(0));
                else check("x8_data", 64'({ovf8, cout8, 24'h0, s8}), 64'(q8.pop_front()));
            end
            if (in_valid && in_ready8) q8.push_back(ref_op(8, a32, b32, cin, sub));
            if (out_valid32) begin
                if (q32.size() == 0) check("x32_spurious", 64'(out_valid32), 64'(0));
                else check("x32_data", 64'({ovf32, cout32, s32}), 64'(q32.pop_front()));
            end
            if (in_valid && in_ready32) q32.push_back(ref_op(32, a32, b32, cin, sub));
        end
    end

    task automatic rand_ops();
        a32 = $urandom;
        b32 = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One op into an empty pipe; checks latency and the result values
    task automatic run_one(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                           input logic ts, input logic [15:0] es, input logic eco,
                           input logic eov);
        int lat;
        a32 = {16'h0000, ta};
        b32 = {16'h0000, tb};
        cin = tc;
        sub = ts;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check("dir_in_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("dir_latency", 64'(lat), 64'(L));
        check("dir_s", 64'(s), 64'(es));
        check("dir_cout", 64'(cout), 64'(eco));
        check("dir_ovf", 64'(ovf), 64'(eov));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, n0;
        logic [17:0] snap;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a32 = '0;
        b32 = '0;
        cin = 1'b0;
        sub = 1'b0;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_s", 64'(s), 64'(0));
        #20 rst_n = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed carry/subtract corners
        for (int i = 0; i < 5; i++) run_one(d_a[i], d_b[i], d_c[i], d_sb[i], d_s[i], d_co[i], d_ov[i]);

        // Back-to-back streaming
        a0 = n_acc;
        n0 = n_out;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rand_ops();
            tick();
        end
        in_valid = 1'b0;
        repeat (L + 1) tick();
        check("stream_acc", 64'(n_acc - a0), 64'(200));
        check("stream_out", 64'(n_out - n0), 64'(200));

        // Backpressure with a full pipe
        in_valid = 1'b1;
        repeat (L) begin
            rand_ops();
            tick();
        end
        check("bp_full", 64'(out_valid), 64'(1));
        out_ready = 1'b0;
        rand_ops();
        #1;
        snap = {ovf, cout, s};
        check("bp_in_ready0", 64'(in_ready), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_hold", 64'({ovf, cout, s}), 64'(snap));
        end
        out_ready = 1'b1;
        repeat (3) begin
            rand_ops();
            tick();
        end
        in_valid = 1'b0;
        repeat (L + 2) tick();

        // Random bubbles and backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            rand_ops();
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (L + 2) tick();
        check("rand_drain_m", 64'(qm.size()), 64'(0));
        check("rand_drain_8", 64'(q8.size()), 64'(0));
        check("rand_drain_32", 64'(q32.size()), 64'(0));

        // Reset with three ops in flight, one of them at the output
        in_valid = 1'b1;
        repeat (3) begin
            rand_ops();
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("mid_pre_valid", 64'(out_valid), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_s", 64'(s), 64'(0));
        check("mid_rst_cout", 64'({ovf, cout}), 64'(0));
        tick();
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        run_one(16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0);
        repeat (L + 2) tick();
        check("end_q_m", 64'(qm.size()), 64'(0));
        check("end_q_8", 64'(q8.size()), 64'(0));
        check("end_q_32", 64'(q32.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
